// File: rtl/lfsr_random_unit.sv
// Parametrised Fibonacci-style LFSR with reseed, zero-lockup recovery and a bounded
// req/valid draw port (masked rejection sampling, capped retries, then a folded fallback).
module lfsr_random_unit #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   TAPS      = 32'h80200003,
  parameter logic [WIDTH-1:0]   SEED      = 32'h12345678,
  parameter int                 OUT_WIDTH = 8,
  parameter int                 MAX_TRIES = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 seed_load,
  input  logic [WIDTH-1:0]     seed_value,
  output logic [WIDTH-1:0]     random_number,
  input  logic                 req,
  input  logic [OUT_WIDTH-1:0] range_limit,
  output logic                 busy,
  output logic                 valid,
  output logic [OUT_WIDTH-1:0] value,
  output logic                 lockup
);

  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_lfsr;
  logic                 r_lockup;
  logic [OUT_WIDTH-1:0] r_lim;
  logic [TW-1:0]        r_tries;
  logic [OUT_WIDTH-1:0] r_value;
  logic                 r_valid;
  logic                 r_busy;

  logic [WIDTH-1:0]     w_lfsr_step;
  logic [OUT_WIDTH-1:0] w_lim_m1;
  logic [OUT_WIDTH-1:0] w_mask;
  logic [OUT_WIDTH-1:0] w_cand;

  // Smearing lim-1 rightwards yields the smallest all-ones mask covering [0, lim).
  always_comb begin
    w_lfsr_step = {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};
    w_lim_m1    = r_lim - OUT_WIDTH'(1);
    w_mask      = w_lim_m1;
    for (int s = 1; s < OUT_WIDTH; s = s * 2) begin
      w_mask = w_mask | (w_mask >> s);
    end
    w_cand      = r_lfsr[OUT_WIDTH-1:0] & w_mask;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr   <= SEED;
      r_lockup <= 1'b0;
    end else begin
      r_lockup <= 1'b0;
      if (seed_load) begin
        r_lfsr <= (seed_value == '0) ? SEED : seed_value;
      end else if (r_lfsr == '0) begin
        r_lfsr   <= SEED;
        r_lockup <= 1'b1;
      end else if (enable || r_state == S_DRAW) begin
        r_lfsr <= w_lfsr_step;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_lim   <= '0;
      r_tries <= '0;
      r_value <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_lim   <= range_limit;
            r_tries <= '0;
            r_busy  <= 1'b1;
            if (range_limit == '0) begin
              r_value <= '0;
              r_valid <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_DRAW;
            end
          end
        end
        S_DRAW: begin
          if (w_cand < r_lim) begin
            r_value <= w_cand;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else if (r_tries == TW'(MAX_TRIES - 1)) begin
            // mask < 2*lim, so one subtraction lands the rejected candidate in range.
            r_value <= w_cand - r_lim;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_tries <= r_tries + TW'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign random_number = r_lfsr;
  assign busy          = r_busy;
  assign valid         = r_valid;
  assign value         = r_value;
  assign lockup        = r_lockup;

endmodule

// File: tb/tb_lfsr_random_unit.sv
// Directed bench for lfsr_random_unit: stepping, reseed, draw latency/values, retry cap, lockup, reset.
module tb_lfsr_random_unit;

  localparam logic [31:0] SEED = 32'h12345678;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        seed_load;
  logic [31:0] seed_value;
  logic [31:0] random_number;
  logic        req;
  logic [7:0]  range_limit;
  logic        busy;
  logic        valid;
  logic [7:0]  value;
  logic        lockup;

  logic        req2;
  logic [31:0] random_number2;
  logic        busy2;
  logic        valid2;
  logic [7:0]  value2;
  logic        lockup2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  lfsr_random_unit dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .seed_load(seed_load),
    .seed_value(seed_value), .random_number(random_number), .req(req),
    .range_limit(range_limit), .busy(busy), .valid(valid), .value(value), .lockup(lockup)
  );

  lfsr_random_unit #(.MAX_TRIES(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .seed_load(seed_load),
    .seed_value(seed_value), .random_number(random_number2), .req(req2),
    .range_limit(range_limit), .busy(busy2), .valid(valid2), .value(value2), .lockup(lockup2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_seed(input logic [31:0] s);
    seed_load  = 1'b1;
    seed_value = s;
    tick();
    seed_load  = 1'b0;
  endtask

  // Counts cycles from the acceptance edge (cycle N+1 = 1) until valid is seen.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!valid && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int  cyc;
    logic ok_busy;
    reset_n = 1'b0; enable = 1'b0; seed_load = 1'b0; seed_value = '0;
    req = 1'b0; req2 = 1'b0; range_limit = '0;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    chk("rst_lfsr",   random_number, SEED);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_valid",  32'(valid), 32'd0);
    chk("rst_value",  32'(value), 32'd0);
    chk("rst_lockup", 32'(lockup), 32'd0);

    // 0x12345678 has taps 21 set and 31,1,0 clear -> feedback bit 1.
    enable = 1'b1; tick(); enable = 1'b0;
    chk("step1", random_number, 32'h2468ACF1);
    tick(); tick();
    chk("hold", random_number, 32'h2468ACF1);

    load_seed(32'h0);
    chk("seed0_lfsr", random_number, SEED);
    chk("seed0_lockup", 32'(lockup), 32'd0);
    load_seed(32'hDEADBEEF);
    chk("seed_dead", random_number, 32'hDEADBEEF);

    // Candidates FF FE FD FB F6 ED DB rejected, B6 accepted; mid-draw req ignored.
    load_seed(32'h000000FF);
    range_limit = 8'd200; req = 1'b1; tick(); req = 1'b0; range_limit = 8'd3;
    cyc = 1; ok_busy = 1'b1;
    while (!valid && cyc < 40) begin
      ok_busy &= busy;
      if (cyc == 3) begin req = 1'b1; range_limit = 8'd1; end
      else req = 1'b0;
      tick();
      cyc++;
    end
    req = 1'b0;
    chk("d200_lat",   32'(cyc), 32'd9);
    chk("d200_value", 32'(value), 32'hB6);
    chk("d200_busy",  32'(ok_busy & busy), 32'd1);
    chk("d200_lfsr",  random_number, 32'h0000FF6D);
    tick();
    chk("d200_vpulse", 32'(valid), 32'd0);
    chk("d200_vhold",  32'(value), 32'hB6);
    chk("d200_idle",   32'(busy), 32'd0);

    // Retry cap of 2: FF, FE rejected -> 254-200.
    load_seed(32'h000000FF);
    range_limit = 8'd200; req2 = 1'b1; tick(); req2 = 1'b0;
    cyc = 1;
    while (!valid2 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("cap_lat",   32'(cyc), 32'd3);
    chk("cap_value", 32'(value2), 32'h36);

    range_limit = 8'd1; req = 1'b1; tick(); req = 1'b0;
    wait_valid(cyc);
    chk("lim1_lat",   32'(cyc), 32'd2);
    chk("lim1_value", 32'(value), 32'd0);
    tick();

    load_seed(32'h000000FF);
    range_limit = 8'd200; req = 1'b1; tick(); req = 1'b0;
    wait_valid(cyc);
    chk("reload_value", 32'(value), 32'hB6);
    tick();
    range_limit = 8'd0; req = 1'b1; tick(); req = 1'b0;
    chk("lim0_valid", 32'(valid), 32'd1);
    chk("lim0_value", 32'(value), 32'd0);
    chk("lim0_busy",  32'(busy), 32'd1);
    tick();
    chk("lim0_busy_after", 32'(busy), 32'd0);

    dut.r_lfsr = '0;
    #1;
    chk("zero_forced", random_number, 32'd0);
    tick();
    chk("lock_lfsr",  random_number, SEED);
    chk("lock_pulse", 32'(lockup), 32'd1);
    tick();
    chk("lock_clear", 32'(lockup), 32'd0);

    load_seed(32'h000000FF);
    range_limit = 8'd200; req = 1'b1; tick(); req = 1'b0;
    tick(); tick();
    chk("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_busy",  32'(busy), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_lfsr",  random_number, SEED);
    chk("arst_value", 32'(value), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
